// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// fixed window of GATE_CYCLES clocks after a start request.
module freq_gate_counter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             valid
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    sync_prev_q;
    logic                    edge_pulse;
    logic [GW-1:0]           gate_q, gate_d;
    logic [CNT_W-1:0]        acc_q, acc_d;
    logic                    acc_full;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    valid_q, valid_d;
    logic                    busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    assign acc_full   = &acc_q;

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = GATE;
                    gate_d  = GATE_LAST;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            GATE: begin
                if (edge_pulse) begin
                    if (acc_full) ovf_d = 1'b1;
                    else          acc_d = acc_q + 1'b1;
                end
                // The final gate cycle's pulse is folded in before publishing.
                if (gate_q == '0) begin
                    state_d    = DONE;
                    count_d    = acc_d;
                    overflow_d = ovf_d;
                    valid_d    = 1'b1;
                end else begin
                    gate_d = gate_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign busy     = busy_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;
endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: a 32-bit and a saturating 4-bit instance share
// stimulus; a window-sum reference model predicts every output each cycle.
module tb_freq_gate_counter;
    localparam int G    = 100;
    localparam int S    = 2;
    localparam int HMAX = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sig_in = 1'b0;
    logic        busy_a, valid_a, ovf_a;
    logic [31:0] cnt_a;
    logic        busy_b, valid_b, ovf_b;
    logic [3:0]  cnt_b;

    freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(32), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .sig_in(sig_in),
        .count(cnt_a), .overflow(ovf_a), .valid(valid_a));

    freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S)) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .sig_in(sig_in),
        .count(cnt_b), .overflow(ovf_b), .valid(valid_b));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: absolute edge index, sampled input history.
    int          e = 0;
    int          last_rst = 0;
    int          s_edge = 0;
    bit          m_act = 1'b0;
    bit          hist [HMAX];
    logic        m_busy = 1'b0, m_valid = 1'b0;
    logic [31:0] m_cnt_a = '0;
    logic        m_ovf_a = 1'b0;
    logic [3:0]  m_cnt_b = '0;
    logic        m_ovf_b = 1'b0;

    int mode = 0, per_v = 1, ph = 0, rleft = 0;

    function automatic bit h(int i);
        if (i <= last_rst) return 1'b0;
        return hist[i % HMAX];
    endfunction

    // A rise sampled at edge i is seen as a pulse counted at edge i+S.
    task automatic model_edge();
        int n;
        e = e + 1;
        hist[e % HMAX] = sig_in;
        m_valid = 1'b0;
        if (rst) begin
            last_rst = e;
            m_act    = 1'b0;
            m_cnt_a  = '0;
            m_ovf_a  = 1'b0;
            m_cnt_b  = '0;
            m_ovf_b  = 1'b0;
        end else begin
            if (!m_act && start) begin
                m_act  = 1'b1;
                s_edge = e;
            end else if (m_act && e == s_edge + G + 1) begin
                m_act = 1'b0;
            end
            if (m_act && e == s_edge + G) begin
                n = 0;
                for (int k = s_edge + 1; k <= s_edge + G; k++)
                    n += int'(h(k - S) & ~h(k - S - 1));
                m_cnt_a = n;
                m_ovf_a = 1'b0;
                m_cnt_b = (n > 15) ? 4'd15 : 4'(n);
                m_ovf_b = (n > 15);
                m_valid = 1'b1;
            end
        end
        m_busy = m_act;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
        end
    endtask

    task automatic check_cycle();
        cmp("busy_a",  32'(busy_a),  32'(m_busy));
        cmp("valid_a", 32'(valid_a), 32'(m_valid));
        cmp("count_a", cnt_a,        m_cnt_a);
        cmp("ovf_a",   32'(ovf_a),   32'(m_ovf_a));
        cmp("busy_b",  32'(busy_b),  32'(m_busy));
        cmp("valid_b", 32'(valid_b), 32'(m_valid));
        cmp("count_b", 32'(cnt_b),   32'(m_cnt_b));
        cmp("ovf_b",   32'(ovf_b),   32'(m_ovf_b));
    endtask

    task automatic step();
        case (mode)
            1: begin
                ph = (ph + 1) % per_v;
                sig_in = (ph < per_v / 2);
            end
            2: begin
                if (rleft == 0) begin
                    sig_in = ~sig_in;
                    rleft  = $urandom_range(2, 7);
                end
                rleft--;
            end
            default: ;
        endcase
        @(posedge clk);
        model_edge();
        #3;
        check_cycle();
    endtask

    task automatic set_mode(input int per);
        if (per > 0) begin
            mode  = 1;
            per_v = per;
            ph    = 0;
        end else begin
            mode   = 0;
            sig_in = 1'b0;
        end
    endtask

    task automatic run_meas(input string nm, input int per, input logic [31:0] xa,
                            input logic xoa, input logic [3:0] xb, input logic xob,
                            input bit noisy);
        int t, blen, vcnt;
        logic [31:0] ca;
        logic [3:0]  cb;
        logic        oa, ob;
        ca = '0; cb = '0; oa = 1'b0; ob = 1'b0;
        set_mode(per);
        repeat (16) step();
        start = 1'b1;
        step();
        t = 0;
        while (!busy_a && t < 5) begin step(); t++; end
        cmp({nm, "_busy_seen"}, 32'(busy_a), 32'd1);
        start = 1'b0;
        blen = 0; vcnt = 0; t = 0;
        while (busy_a && t < G + 10) begin
            blen++;
            if (valid_a) begin
                vcnt++;
                ca = cnt_a; oa = ovf_a; cb = cnt_b; ob = ovf_b;
            end
            start = (noisy && t < 80) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            t++;
        end
        start = 1'b0;
        cmp({nm, "_busy_len"}, 32'(blen), 32'(G + 1));
        cmp({nm, "_valid_pulses"}, 32'(vcnt), 32'd1);
        cmp({nm, "_count_a"}, ca, xa);
        cmp({nm, "_ovf_a"}, 32'(oa), 32'(xoa));
        cmp({nm, "_count_b"}, 32'(cb), 32'(xb));
        cmp({nm, "_ovf_b"}, 32'(ob), 32'(xob));
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] xa);
        int t;
        t = 0;
        while (!valid_a && t < 10) begin step(); t++; end
        cmp({nm, "_valid_seen"}, 32'(valid_a), 32'd1);
        cmp({nm, "_count_a"}, cnt_a, xa);
        cmp({nm, "_count_b"}, 32'(cnt_b), 32'(xa[3:0]));
        step();
    endtask

    typedef struct {
        int          per;
        logic [31:0] ca;
        logic        oa;
        logic [3:0]  cb;
        logic        ob;
        bit          noisy;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int s;
        tbl[0] = '{10, 32'd10, 1'b0, 4'd10, 1'b0, 1'b0};
        tbl[1] = '{ 4, 32'd25, 1'b0, 4'd15, 1'b1, 1'b0};
        tbl[2] = '{ 0, 32'd0,  1'b0, 4'd0,  1'b0, 1'b0};
        tbl[3] = '{10, 32'd10, 1'b0, 4'd10, 1'b0, 1'b1};

        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 4; i++)
            run_meas($sformatf("vec%0d", i), tbl[i].per, tbl[i].ca, tbl[i].oa,
                     tbl[i].cb, tbl[i].ob, tbl[i].noisy);

        // Abort mid-gate with a previous result of 10 on both instances.
        set_mode(10);
        repeat (16) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("abort_busy", 32'(busy_a), 32'd0);
        cmp("abort_count", cnt_a, 32'd0);
        cmp("abort_valid", 32'(valid_a), 32'd0);
        run_meas("post_abort", 10, 32'd10, 1'b0, 4'd10, 1'b0, 1'b0);

        // Rises landing on the first and last gate cycles are both counted.
        set_mode(0);
        repeat (6) step();
        sig_in = 1'b1;
        step();
        start = 1'b1;
        step();
        s = e;
        start = 1'b0;
        repeat (10) step();
        sig_in = 1'b0;
        while (e < s + G - 3) step();
        sig_in = 1'b1;
        step();
        wait_valid("edge_in", 32'd2);

        // Rises one cycle before and one cycle after the window are not.
        sig_in = 1'b0;
        repeat (6) step();
        sig_in = 1'b1;
        step();
        step();
        start = 1'b1;
        step();
        s = e;
        start = 1'b0;
        repeat (10) step();
        sig_in = 1'b0;
        while (e < s + G - 2) step();
        sig_in = 1'b1;
        step();
        wait_valid("edge_out", 32'd0);

        // Random signal, random start requests and occasional resets.
        mode = 2;
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (G + 5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
